delay_timer: RTL and testbench
==============================

Name: delay_timer

Overview:
- Parametrised, runtime-programmable successor to the fixed 2 ms delay generator used by the game-control FSMs (LCD/display init, debounce, move timeouts).
- Delay is loaded per request in prescaled ticks. Supports one-shot or periodic mode, retrigger and cancel.
- Signals completion with a single-cycle delayDone pulse.
- Sits between the top-level game controller and any sub-FSM that needs timed waits, replacing per-delay hard-coded counters.

Parameters:
- PRESCALE, 100, clock cycles per tick (100 = 1 us at 100 MHz); legal range >= 1.
- CNT_W, 16, width of delayTicks and elapsedTicks.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request, sampled each edge; latches delayTicks and periodic
- delayTicks  in  CNT_W  delay length N in ticks; sampled only with start
- periodic  in  1  1 = auto-reload after each expiry; sampled only with start
- cancel  in  1  abort active delay, no pulse
- busy  out  1  high while a delay is running (state RUN)
- delayDone  out  1  registered one-cycle expiry pulse
- elapsedTicks  out  CNT_W  ticks completed in the current period

Behaviour:
- Reset (async assert, released synchronously by the system): state=IDLE, prescaler=0, tick count=0, busy=0, delayDone=0, elapsedTicks=0. Reset mid-run kills the delay immediately. No pulse is produced after release.
- States:
  - IDLE: no delay running.
  - RUN: prescaler counts 0..PRESCALE-1 and wraps. On wrap, the tick count increments.
- Start accepted at edge k with N = delayTicks:
  - If N != 0: state<=RUN, prescaler<=0, count<=0, latch N and periodic.
  - If N = 0: delayDone<=1 at edge k, state stays IDLE. The periodic flag is ignored (treated as one-shot).
- Terminal condition, evaluated in RUN: prescaler==PRESCALE-1 and count==N-1. When true, delayDone<=1 at that edge. Net timing: delayDone rises at edge k+N*PRESCALE (N=0 gives edge k).
- On terminal, one-shot: state<=IDLE at the same edge, so busy falls as delayDone rises.
- On terminal, periodic: prescaler<=0, count<=0, stay RUN. Pulses repeat every N*PRESCALE cycles until cancel or start.
- delayDone is high for exactly one cycle per expiry and is never held.
- Priority, highest first: reset > cancel > start > terminal.
  - cancel in RUN: state<=IDLE, counters<=0, no pulse, even if terminal occurs in the same cycle.
  - cancel in IDLE: no effect. cancel together with start: the start is dropped.
  - start in RUN (retrigger): reload as a fresh start with the new N and periodic. A coincident terminal pulse is suppressed.
- elapsedTicks = count; range 0..N-1 and never wraps within a period; reads 0 in IDLE.
- Width rules:
  - Prescaler width is max(1, clog2(PRESCALE)).
  - Tick count is CNT_W bits. Max N = 2^CNT_W-1 and needs no extra bit, since the compare is against N-1.
  - PRESCALE=1: the prescaler is constant 0 and every cycle is a tick.
- delayTicks and periodic are don't-care except in cycles where start=1.

Decomposition:
- Shared package (game-wide timing pkg):
  - state typedef {IDLE, RUN};
  - constant CLK_FREQ_HZ = 100_000_000;
  - helper constants for common delays, e.g. DLY_2MS_TICKS = 2000 at PRESCALE=100.
- One natural sub-module: delay_prescaler. Inputs: clock, reset, clear, enable. Output: a tick strobe at PRESCALE-1. Parameter: PRESCALE.
- delay_timer keeps the FSM, tick counter, compare and priority logic.

Test Plan (PRESCALE=4, CNT_W=8):
1. start at edge k, delayTicks=3, periodic=0 -> busy high after k; delayDone high only in the cycle after edge k+12; busy low from k+12; elapsedTicks steps 0,1,2.
2. start at k, delayTicks=2, periodic=1; cancel at edge k+20 -> pulses after k+8 and k+16 only; busy low from k+20; no pulse at k+24.
3. start at k, delayTicks=0, periodic=1 -> delayDone pulses after edge k; busy never asserts; no further pulses.
4. start at k with N=5, then start at k+10 with N=1 -> single pulse at k+14; nothing at k+20. Then cancel coincident with a terminal cycle -> no pulse, IDLE.
5. Reset asserted asynchronously mid-run (N=10, cycle k+17) -> busy, delayDone and elapsedTicks go 0 without a clock edge; after release, no pulse until a new start.
6. start with N=255 -> delayDone at edge k+1020; elapsedTicks peaks at 254 with no overflow; start+cancel in the same cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Game-wide timing constants and the delay timer state type.
package delay_timer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;

  localparam int CLK_FREQ_HZ   = 100_000_000;
  localparam int DLY_PRESCALE  = 100;
  localparam int DLY_2MS_TICKS = 2000;
  localparam int DLY_20MS_TICKS = 20000;

  function automatic int ticks_for_us(input int us, input int prescale);
    return (us * (CLK_FREQ_HZ / 1_000_000)) / prescale;
  endfunction
endpackage

// File: rtl/delay_timer_if.sv
// Request/status bundle between a controller FSM and the delay timer.
interface delay_timer_if #(parameter int CNT_W = 16);
  logic             start;
  logic [CNT_W-1:0] delayTicks;
  logic             periodic;
  logic             cancel;
  logic             busy;
  logic             delayDone;
  logic [CNT_W-1:0] elapsedTicks;

  modport master (output start, delayTicks, periodic, cancel,
                  input  busy, delayDone, elapsedTicks);
  modport slave  (input  start, delayTicks, periodic, cancel,
                  output busy, delayDone, elapsedTicks);
endinterface

// File: rtl/delay_timer_prescaler.sv
// Free-running cycle prescaler; strobes tick_o on the last cycle of each tick.
module delay_timer_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // PRESCALE=1 leaves cnt_q pinned at 0, so every enabled cycle is a tick.
  assign tick_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot/periodic delay timer with retrigger and cancel.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int PRESCALE = 100,
  parameter int CNT_W    = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  delay_timer_if.slave bus
);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             per_q, per_d;
  logic             done_q, done_d;
  logic             run, tick, pre_clr;

  assign run     = (state_q == S_RUN);
  assign pre_clr = !run || bus.cancel || bus.start;

  delay_timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (pre_clr),
    .enable_i (run),
    .tick_o   (tick)
  );

  // Priority: cancel > start > terminal; a start always resets the period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    per_d   = per_q;
    done_d  = 1'b0;
    if (bus.cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (bus.start) begin
      cnt_d = '0;
      if (bus.delayTicks != '0) begin
        state_d = S_RUN;
        n_d     = bus.delayTicks;
        per_d   = bus.periodic;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end else if (run && tick) begin
      if (cnt_q == n_q - 1'b1) begin
        done_d = 1'b1;
        cnt_d  = '0;
        if (!per_q) state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      per_q   <= per_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy         = run;
  assign bus.delayDone    = done_q;
  assign bus.elapsedTicks = cnt_q;
endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench: deadline-based reference model vs delay_timer at PRESCALE=4, CNT_W=8.
module tb_delay_timer;
  localparam int P = 4;
  localparam int W = 8;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [W-1:0] el;
    int           edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_timer_if #(.CNT_W(W)) bus ();
  delay_timer #(.PRESCALE(P), .CNT_W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: a running delay is its start edge plus a length in cycles.
  int  e = 0;
  bit  m_act = 0;
  int  m_t0 = 0;
  int  m_n = 0;
  bit  m_per = 0;

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic cyc(input bit st, input int n, input bit per, input bit can);
    exp_t x;
    bit done;
    @(negedge clk);
    bus.start      = st;
    bus.delayTicks = W'(n);
    bus.periodic   = per;
    bus.cancel     = can;
    e++;
    done = 0;
    if (can) m_act = 0;
    else if (st) begin
      if (n != 0) begin m_act = 1; m_t0 = e; m_n = n; m_per = per; end
      else begin m_act = 0; done = 1; end
    end else if (m_act && (e - m_t0 == m_n * P)) begin
      done = 1;
      if (m_per) m_t0 = e; else m_act = 0;
    end
    x.busy = m_act;
    x.done = done;
    x.el   = m_act ? W'((e - m_t0) / P) : '0;
    x.edge_no = e;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, $urandom_range(0, 255), $urandom_range(0, 1), 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if (bus.busy !== x.busy || bus.delayDone !== x.done || bus.elapsedTicks !== x.el) begin
          bad++;
          $display("FAIL cycle%0d: got busy=%b done=%b el=%0d want busy=%b done=%b el=%0d",
                   x.edge_no, bus.busy, bus.delayDone, bus.elapsedTicks, x.busy, x.done, x.el);
        end
      end
    end
  end

  initial begin : stim
    bus.start = 0; bus.delayTicks = '0; bus.periodic = 0; bus.cancel = 0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.delayDone), 0);
    check("rst_el", int'(bus.elapsedTicks), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    idle(3);

    // 1: one-shot N=3
    cyc(1, 3, 0, 0); idle(16);
    // 2: periodic N=2, cancel at k+20
    cyc(1, 2, 1, 0); idle(19); cyc(0, 0, 0, 1); idle(8);
    // 3: N=0 with periodic set
    cyc(1, 0, 1, 0); idle(10);
    // 4: retrigger N=5 -> N=1 at k+10
    cyc(1, 5, 0, 0); idle(9); cyc(1, 1, 0, 0); idle(12);
    //    cancel coincident with terminal
    cyc(1, 2, 0, 0); idle(7); cyc(0, 0, 0, 1); idle(4);
    //    retrigger coincident with terminal
    cyc(1, 1, 1, 0); idle(3); cyc(1, 2, 0, 0); idle(10);
    // 5: async reset mid-run
    cyc(1, 10, 0, 0); idle(17);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.delayDone), 0);
    check("arst_el", int'(bus.elapsedTicks), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    m_act = 0;
    idle(50);
    // 6: max N, then start+cancel from IDLE
    cyc(1, 255, 0, 0); idle(1024);
    cyc(1, 7, 1, 1); idle(40);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      int n;
      r = $urandom_range(0, 99);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      cyc(r < 5, n, $urandom_range(0, 1), r >= 97);
    end
    idle(2);
    @(negedge clk); @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
